// File: rtl/adder_seq_pkg.sv
// ---------------------------------------------------------------------------
// adder_seq_pkg : shared state encoding and constants for adder_seq_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package adder_seq_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int MAX_OPS       = 4;
  localparam int OPS_W         = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic ops_legal(input logic [OPS_W-1:0] n);
    return (n != '0) && (n <= OPS_W'(MAX_OPS));
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder32.sv
// ---------------------------------------------------------------------------
// adder32 : combinational WIDTH-bit a + b + cin with carry-out
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adder32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// adder_seq_ctrl : sums up to four register slots through one shared adder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int NUM_SLOTS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0] wr_sel,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         cin,
  input  logic                         start,
  input  logic [OPS_W-1:0]             num_ops,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             result,
  output logic [OPS_W-1:0]             carry_cnt,
  output logic                         err
);

  localparam int SEL_W = $clog2(NUM_SLOTS);

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       slots_q [NUM_SLOTS];
  logic [WIDTH-1:0]       slots_d [NUM_SLOTS];
  logic [OPS_W-1:0]       num_ops_q, num_ops_d;
  logic                   cin_q, cin_d;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic [OPS_W-1:0]       carry_q, carry_d;
  logic [OPS_W-1:0]       idx_q, idx_d;
  logic                   err_q, err_d;

  logic [WIDTH-1:0]       w_operand;
  logic                   w_add_cin;
  logic [WIDTH-1:0]       w_sum;
  logic                   w_cout;

  // Carry-in only enters the first addition of a summation.
  assign w_operand = slots_q[idx_q[SEL_W-1:0]];
  assign w_add_cin = (idx_q == '0) ? cin_q : 1'b0;

  adder32 #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_q),
    .b    (w_operand),
    .cin  (w_add_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_comb begin
    state_d   = state_q;
    slots_d   = slots_q;
    num_ops_d = num_ops_q;
    cin_d     = cin_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_valid) slots_d[wr_sel] = wr_data;
        if (start) begin
          if (ops_legal(num_ops)) begin
            num_ops_d = num_ops;
            cin_d     = cin;
            acc_d     = '0;
            carry_d   = '0;
            idx_d     = '0;
            state_d   = ACC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACC: begin
        acc_d   = w_sum;
        carry_d = carry_q + OPS_W'(w_cout);
        idx_d   = idx_q + OPS_W'(1);
        if (idx_q == num_ops_q - OPS_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
      num_ops_q <= '0;
      cin_q     <= 1'b0;
      acc_q     <= '0;
      carry_q   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slots_q   <= slots_d;
      num_ops_q <= num_ops_d;
      cin_q     <= cin_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = acc_q;
  assign carry_cnt = carry_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 Parameter: NUM_SLOTS, 4, number of operand slots.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_valid  input  1  operand write strobe.
REQ-006 wr_sel  input  2  target slot index 0..3.
REQ-007 wr_data  input  WIDTH  operand value to write.
REQ-008 cin  input  1  carry-in applied to the first addition only.
REQ-009 start  input  1  single-cycle request to begin a summation.
REQ-010 num_ops  input  3  operand count, legal range 1..4.
REQ-011 busy  output  1  high in ACC and DONE states.
REQ-012 done  output  1  one-cycle pulse, result valid.
REQ-013 result  output  WIDTH  sum modulo 2^WIDTH of slots 0..num_ops-1 plus cin.
REQ-014 carry_cnt  output  3  number of carry-outs produced during the summation (0..4).
REQ-015 err  output  1  one-cycle pulse on rejected start.

Function
REQ-016 FSM states SHALL be IDLE, ACC, DONE; reset state IDLE.
REQ-017 In IDLE, wr_valid SHALL write wr_data into slot[wr_sel] at the clock edge; in ACC/DONE, writes SHALL be ignored.
REQ-018 In IDLE, start with num_ops in 1..4 SHALL latch num_ops and cin, clear acc, carry_cnt and idx to 0, and enter ACC.
REQ-019 In IDLE, start with num_ops of 0 or 5..7 SHALL pulse err for one cycle and leave the state at IDLE.
REQ-020 Start in ACC or DONE SHALL be ignored, with no err pulse.
REQ-021 A write and an accepted start in the same IDLE cycle SHALL both take effect; the summation SHALL use the newly written value.
REQ-022 Each ACC cycle SHALL compute acc <= acc + slot[idx] + (idx==0 ? latched cin : 0) through one shared WIDTH-bit adder.
REQ-023 Each ACC cycle SHALL also apply carry_cnt += cout and idx += 1.
REQ-024 After the cycle with idx == latched num_ops-1, the FSM SHALL enter DONE.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 Latency: start accepted at edge T SHALL give done high in the cycle after edge T+num_ops, i.e. num_ops+1 cycles after start.
REQ-027 result and carry_cnt SHALL hold their final values from DONE until the next accepted start.
REQ-028 result SHALL wrap modulo 2^WIDTH; carry_cnt SHALL NOT saturate, since its maximum is 4.

Reset
REQ-029 Reset asserted at any time, including mid-ACC, SHALL immediately force IDLE and clear busy, done, err, result, carry_cnt, idx, the latched num_ops/cin and all slots to 0.
REQ-030 After reset deasserts, the first rising edge SHALL accept writes and start normally.

Structure
REQ-031 Shared package adder_seq_pkg SHALL hold the state encoding (IDLE/ACC/DONE), the WIDTH default and the MAX_OPS=4 constant.
REQ-032 The datapath SHALL instantiate exactly one sub-module, adder32: combinational WIDTH-bit a+b+cin with outputs sum and cout.
REQ-033 Slot storage SHALL be registers, not inferred RAM.

Verification
REQ-034 Write slots 1,2,3,4; num_ops=4, cin=0 -> done 5 cycles after start, result=10, carry_cnt=0.
REQ-035 Slots 0xFFFFFFFF, 0x00000001; num_ops=2, cin=1 -> result=0x00000001, carry_cnt=1.
REQ-036 Start with num_ops=0, then with num_ops=5 -> one err pulse each, busy stays 0, result unchanged.
REQ-037 During ACC, write slot0=0xAAAA and pulse start -> both ignored; the running sum uses the old slot0; no err pulse.
REQ-038 Assert reset on the 2nd ACC cycle -> busy=0 and all outputs 0 asynchronously; a following num_ops=1 summation of zeroed slots with cin=1 gives result=1.
REQ-039 Write slot0=7 in the same cycle as start, num_ops=1, cin=0 -> result=7 two cycles later.
